// File: rtl/bus_arbiter_if.sv
// Signal bundle between the pipeline's IF/MEM access ports, the arbiter and the bus pins.
// The arbiter uses the slave view; the pipeline/bus side uses the master view.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [CTRL_W-1:0] dm_ctrl;
  logic [DATA_W-1:0] dm_wd;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              stall_if;
  logic              stall_dm;
  logic [ADDR_W-1:0] bus_addr;
  logic [CTRL_W-1:0] bus_ctrl;
  logic [DATA_W-1:0] bus_wd;
  logic              bus_we;
  logic [DATA_W-1:0] bus_rd;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_ctrl, dm_wd, bus_rd,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           stall_if, stall_dm, bus_addr, bus_ctrl, bus_wd, bus_we
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_ctrl, dm_wd, bus_rd,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           stall_if, stall_dm, bus_addr, bus_ctrl, bus_wd, bus_we
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares the single external bus between instruction fetch and data access:
// data has priority, a starvation counter lets fetch through, read data returns one cycle late.
//
// state | meaning
// IDLE  | no read in flight
// RD_IF | fetch read in flight, bus_rd returns to the IF port this cycle
// RD_DM | data read in flight, bus_rd returns to the MEM port this cycle
module bus_arbiter #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              CTRL_W     = 3,
  parameter int              MAX_STARVE = 4,
  parameter logic [CTRL_W-1:0] CTRL_WORD = CTRL_W'(3'b010)
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} state_t;

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              starved;
  logic              if_gnt, dm_gnt;
  logic              if_rvalid, dm_rvalid;
  logic [DATA_W-1:0] if_hold, dm_hold;
  logic [ADDR_W-1:0] bus_addr;
  logic [CTRL_W-1:0] bus_ctrl;
  logic [DATA_W-1:0] bus_wd;
  logic              bus_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      if_hold    <= '0;
      dm_hold    <= '0;
    end else begin
      state <= state_nxt;
      if (if_rvalid) if_hold <= arb.bus_rd;
      if (dm_rvalid) dm_hold <= arb.bus_rd;
      if (if_gnt || !arb.if_req)
        starve_cnt <= 4'd0;
      else if (dm_gnt && !starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    starved   = (starve_cnt == 4'(MAX_STARVE));
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    bus_addr  = '0;
    bus_ctrl  = '0;
    bus_wd    = '0;
    bus_we    = 1'b0;
    state_nxt = IDLE;
    if_rvalid = (state == RD_IF) && !rst;
    dm_rvalid = (state == RD_DM) && !rst;

    // Data wins contention except on the one cycle the starvation counter hands it to fetch.
    if (!rst) begin
      if (arb.if_req && (!arb.dm_req || starved))
        if_gnt = 1'b1;
      else if (arb.dm_req)
        dm_gnt = 1'b1;
    end

    if (if_gnt) begin
      bus_addr  = arb.if_addr;
      bus_ctrl  = CTRL_WORD;
      state_nxt = RD_IF;
    end else if (dm_gnt) begin
      bus_addr  = arb.dm_addr;
      bus_ctrl  = arb.dm_ctrl;
      bus_wd    = arb.dm_wd;
      bus_we    = arb.dm_we;
      state_nxt = arb.dm_we ? IDLE : RD_DM;
    end
  end

  assign arb.if_gnt    = if_gnt;
  assign arb.dm_gnt    = dm_gnt;
  assign arb.if_rvalid = if_rvalid;
  assign arb.dm_rvalid = dm_rvalid;
  assign arb.if_rdata  = if_rvalid ? arb.bus_rd : if_hold;
  assign arb.dm_rdata  = dm_rvalid ? arb.bus_rd : dm_hold;
  assign arb.stall_if  = arb.if_req & ~if_gnt;
  assign arb.stall_dm  = arb.dm_req & ~dm_gnt;
  assign arb.bus_addr  = bus_addr;
  assign arb.bus_ctrl  = bus_ctrl;
  assign arb.bus_wd    = bus_wd;
  assign arb.bus_we    = bus_we;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table for bus_arbiter plus hand-written starvation sequences.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CTRL_W(3)) intf ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CTRL_W(3), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (intf)
  );

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_wd;
    logic [31:0] bus_rd;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_stall_if;
    logic        e_stall_dm;
    logic [31:0] e_bus_addr;
    logic [2:0]  e_bus_ctrl;
    logic [31:0] e_bus_wd;
    logic        e_bus_we;
    logic        e_if_rv;
    logic [31:0] e_if_rdata;
    logic        e_dm_rv;
    logic [31:0] e_dm_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rst;
    intf.if_req  = v.if_req;
    intf.if_addr = v.if_addr;
    intf.dm_req  = v.dm_req;
    intf.dm_we   = v.dm_we;
    intf.dm_addr = v.dm_addr;
    intf.dm_ctrl = v.dm_ctrl;
    intf.dm_wd   = v.dm_wd;
    intf.bus_rd  = v.bus_rd;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #4;
    chk("grant", idx, 128'({intf.if_gnt, intf.dm_gnt, intf.stall_if, intf.stall_dm}),
                      128'({v.e_if_gnt, v.e_dm_gnt, v.e_stall_if, v.e_stall_dm}));
    chk("bus", idx, 128'({intf.bus_addr, intf.bus_ctrl, intf.bus_wd, intf.bus_we}),
                    128'({v.e_bus_addr, v.e_bus_ctrl, v.e_bus_wd, v.e_bus_we}));
    chk("if_ret", idx, 128'({intf.if_rvalid, intf.if_rdata}), 128'({v.e_if_rv, v.e_if_rdata}));
    chk("dm_ret", idx, 128'({intf.dm_rvalid, intf.dm_rdata}), 128'({v.e_dm_rv, v.e_dm_rdata}));
  endtask

  // Both ports request every cycle except where ifreq_pat has a 0; exp_if_pat marks the cycles fetch must win.
  task automatic run_seq(input int n, input logic [15:0] ifreq_pat, input logic [15:0] exp_if_pat, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst          = 1'b0;
      intf.if_req  = ifreq_pat[i];
      intf.if_addr = 32'h0000_0500;
      intf.dm_req  = 1'b1;
      intf.dm_we   = 1'b0;
      intf.dm_addr = 32'h0000_2000;
      intf.dm_ctrl = 3'b010;
      intf.dm_wd   = 32'h0;
      intf.bus_rd  = 32'h0;
      #4;
      chk("starve", base + i, 128'({intf.if_gnt, intf.dm_gnt, intf.stall_if, intf.stall_dm}),
          128'({exp_if_pat[i], ~exp_if_pat[i], ifreq_pat[i] & ~exp_if_pat[i], exp_if_pat[i]}));
    end
    @(negedge clk);
    intf.if_req = 1'b0;
    intf.dm_req = 1'b0;
  endtask

  initial begin
    //          rst   ifq   if_addr       dmq   we    dm_addr       ctrl    dm_wd         bus_rd        ifg   dmg   sti   std   bus_addr      bctrl   bus_wd        bwe   ifrv  if_rdata      dmrv  dm_rdata
    vecs[0]  = '{1'b1, 1'b1, 32'h00000100, 1'b1, 1'b0, 32'h00002000, 3'b010, 32'h0000AAAA, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h0000BBBB, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000100, 3'b010, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000104, 1'b1, 1'b0, 32'h00002000, 3'b010, 32'h0000AAAA, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002000, 3'b010, 32'h0000AAAA, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000104, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000104, 3'b010, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hCAFE0001};
    vecs[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 32'hCAFE0001};
    vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00003000, 3'b010, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00003000, 3'b010, 32'h12345678, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 32'hCAFE0001};
    vecs[9]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 32'hCAFE0001};
    vecs[10] = '{1'b0, 1'b1, 32'h00000200, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000200, 3'b010, 32'h00000000, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 32'hCAFE0001};
    vecs[11] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000400, 3'b100, 32'h00000000, 32'h01020304, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000400, 3'b100, 32'h00000000, 1'b0, 1'b1, 32'h01020304, 1'b0, 32'hCAFE0001};
    vecs[12] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h05060708, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h01020304, 1'b1, 32'h05060708};
    vecs[13] = '{1'b0, 1'b1, 32'h00000300, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000300, 3'b010, 32'h00000000, 1'b0, 1'b0, 32'h01020304, 1'b0, 32'h05060708};
    vecs[14] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h99999999, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h01020304, 1'b0, 32'h05060708};
    vecs[15] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 32'h77777777, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000};

    drive(vecs[0]);
    @(posedge clk);

    for (int i = 0; i < 16; i++) apply_vec(vecs[i], i);

    // Six contended cycles: data wins four times, fetch once, then data again.
    run_seq(6, 16'b0000_0000_0011_1111, 16'b0000_0000_0001_0000, 100);
    // A cycle without a fetch request clears the counter, delaying fetch's turn.
    run_seq(9, 16'b0000_0001_1111_0111, 16'b0000_0001_0000_0000, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the CPU's single external memory/IO bus between the instruction-fetch port (IF stage) and the data port (MEM stage). It grants at most one requester per cycle, drives the granted request onto the bus, and routes the one-cycle-late read data back to the correct requester. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. It sits between the pipeline's IF/MEM access logic and the top-level bus pins.

## Interface
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: bus data width.
- `CTRL_W`, 3: bus access-type width (byte/half/word, signed/unsigned), passed through unchanged.
- `MAX_STARVE`, 4: number of consecutive contended data grants after which fetch wins once (range 1..15).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, held until granted.
- `if_addr`  in  ADDR_W  fetch address; fetch is always a word read.
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  fetch data valid this cycle.
- `if_rdata`  out  DATA_W  fetch read data.
- `dm_req`  in  1  data request, held until granted.
- `dm_we`  in  1  data request is a write.
- `dm_addr`  in  ADDR_W  data address.
- `dm_ctrl`  in  CTRL_W  data access type.
- `dm_wd`  in  DATA_W  write data.
- `dm_gnt`  out  1  data request granted this cycle.
- `dm_rvalid`  out  1  data read result valid this cycle.
- `dm_rdata`  out  DATA_W  data read result.
- `stall_if`  out  1  `if_req & ~if_gnt`.
- `stall_dm`  out  1  `dm_req & ~dm_gnt`.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_ctrl`  out  CTRL_W  bus access type.
- `bus_wd`  out  DATA_W  bus write data.
- `bus_we`  out  1  bus write enable.
- `bus_rd`  in  DATA_W  bus read data, valid one cycle after the address.

## Operation
- Grant is combinational in the cycle of the request.
  - Only one requester: that requester is granted.
  - Both requesting: `dm` is granted, unless `starve_cnt == MAX_STARVE`, in which case `if` is granted.
- `starve_cnt` (4-bit):
  - Increments on each cycle with `if_req & dm_gnt`, saturating at `MAX_STARVE`.
  - Clears to 0 on `if_gnt`, or on any cycle with `if_req == 0`.
- Bus drive in the grant cycle:
  - `if` granted: `bus_addr = if_addr`, `bus_ctrl` = word/unsigned encoding, `bus_we = 0`, `bus_wd = 0`.
  - `dm` granted: `bus_addr = dm_addr`, `bus_ctrl = dm_ctrl`, `bus_wd = dm_wd`, `bus_we = dm_we`.
  - No grant: all bus outputs are 0.
- Read-return FSM; state is the owner of the read in flight: `IDLE`, `RD_IF`, `RD_DM`.
  - Next state is `RD_IF` if `if` was granted, `RD_DM` if a `dm` read was granted, otherwise `IDLE`. A `dm` write always leads to `IDLE`.
  - In `RD_IF`: `if_rvalid = 1` and `if_rdata = bus_rd`. `RD_DM` is symmetric for the `dm` outputs.
  - A new grant is allowed in the same cycle as a return (back-to-back accesses, full throughput).
- Hold registers: each `*_rdata` captures `bus_rd` on its rvalid cycle and presents the held value whenever its rvalid is 0.

## Timing
- Grant and bus drive: 0-cycle latency from request. Read data: exactly 1 cycle after grant. Writes complete in the grant cycle.
- Reset (synchronous, `rst = 1` at the edge):
  - FSM → `IDLE`, `starve_cnt` → 0, both rdata hold registers → 0.
  - Outputs while `rst` is high: `if_gnt = dm_gnt = 0`, `bus_we = 0`, all bus outputs 0, both rvalids 0.
- Reset during an in-flight read: the read is dropped and no rvalid is issued after reset.
- Simultaneous requests in the starvation cycle: `if` wins, `stall_dm = 1`, and the counter clears on the next edge.
- Requester drops its request without a grant: no bus activity and no rvalid.
- `MAX_STARVE` saturation: the counter never wraps.

## Test plan
- Fetch only: `if_req = 1`, `if_addr = 0x100` → same cycle `if_gnt = 1`, `bus_addr = 0x100`; with `bus_rd = 0xDEADBEEF` next cycle → `if_rvalid = 1`, `if_rdata = 0xDEADBEEF`.
- Contention: `if_req = dm_req = 1` (read at `0x2000`) → `dm_gnt = 1`, `stall_if = 1`; next cycle `dm_rvalid = 1`, `dm_rdata = bus_rd`.
- Starvation: both requesting for 6 cycles with `MAX_STARVE = 4` → `dm` granted in cycles 0-3, `if` granted in cycle 4, `dm` granted in cycle 5.
- Write: `dm_we = 1`, `dm_addr = 0x3000`, `dm_wd = 0x12345678`, `dm_ctrl = 3'b010` → `bus_we = 1` with those values in the grant cycle; no rvalid on the following cycle.
- Back-to-back: `if` read then `dm` read on consecutive cycles → `if_rvalid` in cycle 1 and `dm_rvalid` in cycle 2, each carrying its own `bus_rd` value.
- Reset mid-read: grant `if`, assert `rst` on the next edge → no `if_rvalid`, `if_rdata = 0`, FSM in `IDLE`.
